// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: buffers branch resolutions, keeps per-set 2-bit direction
// counters, and runs a drain-then-sweep invalidate of the whole table on request.
module btb_update_ctrl #(
  parameter int unsigned s_index    = 4,
  parameter int unsigned fifo_depth = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_pc,
  input  logic [31:0] res_target,
  input  logic        res_taken,
  input  logic        flush_req,
  output logic        flush_busy,
  output logic        btb_update,
  output logic        btb_update_btb,
  output logic [31:0] btb_pc,
  output logic [31:0] btb_target,
  output logic        btb_p_tnt
);

  localparam int unsigned num_sets = 1 << s_index;
  localparam int unsigned ptr_w    = $clog2(fifo_depth);
  localparam int unsigned cnt_w    = ptr_w + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } entry_t;

  state_t               state_q, state_d;
  logic [ptr_w-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]     rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]     count_q, count_d;
  logic [s_index-1:0]   sweep_idx_q, sweep_idx_d;
  entry_t               fifo_q [fifo_depth];
  entry_t               fifo_d [fifo_depth];
  logic [1:0]           counter_q [num_sets];
  logic [1:0]           counter_d [num_sets];

  entry_t               head;
  logic [s_index-1:0]   head_idx;
  logic [1:0]           cur_c, new_c;
  logic                 empty, full, enq, deq;

  assign empty     = (count_q == '0);
  assign full      = (count_q == cnt_w'(fifo_depth));
  assign res_ready = !full && (state_q == IDLE);
  assign enq       = res_valid && res_ready;
  // The flush_req cycle itself does not dequeue, so everything still queued
  // (including an event accepted alongside the request) is written in DRAIN.
  assign deq       = !empty && ((state_q == DRAIN) || ((state_q == IDLE) && !flush_req));

  assign head     = fifo_q[rd_ptr_q];
  assign head_idx = head.pc[s_index+1:2];
  assign cur_c    = counter_q[head_idx];

  always_comb begin
    new_c = cur_c;
    if (head.taken) begin
      if (cur_c != 2'b11) new_c = cur_c + 2'b01;
    end else begin
      if (cur_c != 2'b00) new_c = cur_c - 2'b01;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sweep_idx_d = sweep_idx_q;
    fifo_d      = fifo_q;
    counter_d   = counter_q;

    if (enq) begin
      fifo_d[wr_ptr_q] = '{pc: res_pc, target: res_target, taken: res_taken};
      wr_ptr_d         = wr_ptr_q + ptr_w'(1);
    end
    if (deq) begin
      rd_ptr_d            = rd_ptr_q + ptr_w'(1);
      counter_d[head_idx] = new_c;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + cnt_w'(1);
      2'b01:   count_d = count_q - cnt_w'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE: if (flush_req) state_d = DRAIN;
      DRAIN: begin
        if (count_d == '0) begin
          state_d     = SWEEP;
          sweep_idx_d = '0;
        end
      end
      SWEEP: begin
        counter_d[sweep_idx_q] = 2'b01;
        sweep_idx_d            = sweep_idx_q + s_index'(1);
        if (sweep_idx_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    btb_update     = 1'b0;
    btb_update_btb = 1'b0;
    btb_pc         = '0;
    btb_target     = '0;
    btb_p_tnt      = 1'b0;
    if (deq) begin
      btb_update     = 1'b1;
      btb_update_btb = head.taken;
      btb_pc         = head.pc;
      btb_target     = head.target;
      btb_p_tnt      = new_c[1];
    end else if (state_q == SWEEP) begin
      // Low bits 2'b11 make the tag misaligned so it can never hit on fetch.
      btb_update     = 1'b1;
      btb_update_btb = 1'b1;
      btb_pc         = {{(30 - s_index){1'b1}}, sweep_idx_q, 2'b11};
    end
  end

  assign flush_busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sweep_idx_q <= '0;
      for (int unsigned i = 0; i < fifo_depth; i++) fifo_q[i] <= '0;
      for (int unsigned i = 0; i < num_sets; i++) counter_q[i] <= 2'b01;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sweep_idx_q <= sweep_idx_d;
      fifo_q      <= fifo_d;
      counter_q   <= counter_d;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: expected BTB writes are queued as events
// and flushes are accepted, then popped and compared as the controller writes.
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic        res_taken;
  logic        flush_req;
  logic        flush_busy;
  logic        btb_update;
  logic        btb_update_btb;
  logic [31:0] btb_pc;
  logic [31:0] btb_target;
  logic        btb_p_tnt;

  btb_update_ctrl #(.s_index(4), .fifo_depth(4)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_pc(res_pc), .res_target(res_target), .res_taken(res_taken),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .btb_update(btb_update), .btb_update_btb(btb_update_btb),
    .btb_pc(btb_pc), .btb_target(btb_target), .btb_p_tnt(btb_p_tnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        upd;
    logic        upd_btb;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        p;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] mdl [16];
  int         vectors = 0;
  int         miscompares = 0;
  int         writes = 0;
  logic [31:0] last_write_pc = '0;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 2'b01;
    sb.delete();
  endfunction

  function automatic void push_event(input logic [31:0] pc, input logic [31:0] tgt,
                                     input logic tk);
    logic [3:0] idx;
    logic [1:0] c, nc;
    exp_t e;
    idx = pc[5:2];
    c   = mdl[idx];
    if (tk) nc = (c == 2'b11) ? 2'b11 : c + 2'b01;
    else    nc = (c == 2'b00) ? 2'b00 : c - 2'b01;
    mdl[idx] = nc;
    e = '{upd: 1'b1, upd_btb: tk, pc: pc, tgt: tgt, p: nc[1]};
    sb.push_back(e);
  endfunction

  function automatic void push_sweep();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      mdl[i] = 2'b01;
      e = '{upd: 1'b1, upd_btb: 1'b1, pc: 32'hFFFF_FFC3 | (32'(i) << 2), tgt: 32'h0, p: 1'b0};
      sb.push_back(e);
    end
  endfunction

  // Sample just before the active edge, then advance to 1 time unit past it.
  task automatic clk_cycle();
    exp_t e;
    exp_t got;
    #3;
    if (rst) begin
      model_reset();
    end else begin
      if (btb_update || btb_update_btb) begin
        writes++;
        last_write_pc = btb_pc;
        got = '{upd: btb_update, upd_btb: btb_update_btb, pc: btb_pc, tgt: btb_target, p: btb_p_tnt};
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write got=%h expected no write", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL btb_write got upd=%b btb=%b pc=%h tgt=%h p=%b expected upd=%b btb=%b pc=%h tgt=%h p=%b",
                     got.upd, got.upd_btb, got.pc, got.tgt, got.p,
                     e.upd, e.upd_btb, e.pc, e.tgt, e.p);
          end
        end
      end
      if (res_valid && res_ready) push_event(res_pc, res_target, res_taken);
      if (flush_req && !flush_busy) push_sweep();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ev(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    res_valid  = 1'b1;
    res_pc     = pc;
    res_target = tgt;
    res_taken  = tk;
  endtask

  task automatic idle_inputs();
    res_valid = 1'b0;
    flush_req = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    vectors++;
    if ({btb_update, btb_update_btb, btb_pc, btb_target, btb_p_tnt} !== 67'd0) begin
      miscompares++;
      $display("FAIL %s outputs upd=%b btb=%b pc=%h tgt=%h p=%b expected all zero",
               name, btb_update, btb_update_btb, btb_pc, btb_target, btb_p_tnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    res_pc = '0; res_target = '0; res_taken = 1'b0;
    clk_cycle();
    clk_cycle();
    rst = 1'b0;
    check_quiet("reset_outputs");
    vectors++;
    if (flush_busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_flush_busy got=%b expected=0", flush_busy);
    end
    vectors++;
    if (res_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_res_ready got=%b expected=1", res_ready);
    end
    model_reset();
    clk_cycle();
  endtask

  task automatic test_single();
    int w0;
    drive_ev(32'h40, 32'h100, 1'b1);
    clk_cycle();
    idle_inputs();
    w0 = writes;
    clk_cycle();
    vectors++;
    if (writes - w0 !== 1) begin
      miscompares++; $display("FAIL single_latency writes=%0d expected=1", writes - w0);
    end
    check_quiet("single_after");
    clk_cycle();
  endtask

  task automatic test_not_taken();
    for (int i = 0; i < 3; i++) begin
      drive_ev(32'h40, 32'h200 + 32'(i), 1'b0);
      clk_cycle();
    end
    idle_inputs();
    clk_cycle();
    clk_cycle();
    check_quiet("not_taken_after");
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [5] = '{32'h80, 32'h84, 32'h80, 32'h9C, 32'h80};
    logic        tks [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int n;
    for (int i = 0; i < 5; i++) begin
      drive_ev(pcs[i], 32'h1000 + 32'(i * 4), tks[i]);
      vectors++;
      if (res_ready !== 1'b1) begin
        miscompares++; $display("FAIL b2b_ready[%0d] got=%b expected=1", i, res_ready);
      end
      clk_cycle();
    end
    drive_ev(32'h88, 32'h2000, 1'b1);
    flush_req = 1'b1;
    clk_cycle();
    flush_req = 1'b0;
    drive_ev(32'hA0, 32'h3000, 1'b1);
    n = 0;
    while (flush_busy && n < 100) begin
      vectors++;
      if (res_ready !== 1'b0) begin
        miscompares++; $display("FAIL b2b_hold_ready got=%b expected=0", res_ready);
      end
      n++;
      clk_cycle();
    end
    vectors++;
    if (flush_busy !== 1'b0) begin
      miscompares++; $display("FAIL b2b_flush_timeout busy=%b expected=0", flush_busy);
    end
    clk_cycle();
    idle_inputs();
    clk_cycle();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL b2b_pending got=%0d expected=0", sb.size());
    end
  endtask

  task automatic test_flush();
    int n, w0;
    drive_ev(32'h44, 32'h500, 1'b1);
    clk_cycle();
    drive_ev(32'h48, 32'h600, 1'b0);
    flush_req = 1'b1;
    clk_cycle();
    idle_inputs();
    n  = 0;
    w0 = writes;
    while (flush_busy && n < 100) begin
      vectors++;
      if (res_ready !== 1'b0) begin
        miscompares++; $display("FAIL flush_ready got=%b expected=0", res_ready);
      end
      n++;
      clk_cycle();
    end
    vectors++;
    if (n != 18) begin
      miscompares++; $display("FAIL flush_busy_len got=%0d expected=18", n);
    end
    vectors++;
    if (writes - w0 != 18) begin
      miscompares++; $display("FAIL flush_writes got=%0d expected=18", writes - w0);
    end
    vectors++;
    if (last_write_pc !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL flush_last_pc got=%h expected=ffffffff", last_write_pc);
    end
    drive_ev(32'h40, 32'h700, 1'b1);
    clk_cycle();
    drive_ev(32'h48, 32'h704, 1'b0);
    clk_cycle();
    idle_inputs();
    clk_cycle();
  endtask

  task automatic test_flush_ignored();
    int n;
    drive_ev(32'h4C, 32'h800, 1'b1);
    clk_cycle();
    idle_inputs();
    flush_req = 1'b1;
    clk_cycle();
    flush_req = 1'b0;
    n = 0;
    while (flush_busy && n < 100) begin
      flush_req = (n == 6 || n == 12);
      n++;
      clk_cycle();
    end
    flush_req = 1'b0;
    vectors++;
    if (n != 17) begin
      miscompares++; $display("FAIL flush_ignored_len got=%0d expected=17", n);
    end
    clk_cycle();
    check_quiet("flush_ignored_after");
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    drive_ev(32'h7C, 32'h900, 1'b1);
    clk_cycle();
    clk_cycle();
    idle_inputs();
    clk_cycle();
    flush_req = 1'b1;
    clk_cycle();
    flush_req = 1'b0;
    n = 0;
    while (btb_pc !== 32'hFFFF_FFD7 && n < 50) begin
      n++;
      clk_cycle();
    end
    vectors++;
    if (btb_pc !== 32'hFFFF_FFD7) begin
      miscompares++; $display("FAIL mid_sweep_reach got=%h expected=ffffffd7", btb_pc);
    end
    rst = 1'b1;
    clk_cycle();
    rst = 1'b0;
    check_quiet("mid_reset_outputs");
    vectors++;
    if (flush_busy !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_busy got=%b expected=0", flush_busy);
    end
    vectors++;
    if (res_ready !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset_ready got=%b expected=1", res_ready);
    end
    drive_ev(32'h7C, 32'hA00, 1'b0);
    clk_cycle();
    drive_ev(32'h1234, 32'hB00, 1'b1);
    clk_cycle();
    idle_inputs();
    clk_cycle();
    clk_cycle();
  endtask

  task automatic test_final_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      n++;
      clk_cycle();
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL final_pending got=%0d expected=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_not_taken();
    test_back_to_back();
    test_flush();
    test_flush_ignored();
    test_reset_mid_sweep();
    test_final_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
